// File: rtl/param_serial_adder_if.sv
// Operand/result bundle for the serial adder: request side (start, a, b)
// and completion side (busy, done, sum, carry).
//
// Handshake: the requester raises start with a/b valid; the adder samples
// start only while idle or done, captures a/b on that edge and raises busy
// on the following cycle. busy stays high for N cycles; done then pulses for
// exactly one cycle, and sum/carry are valid from that cycle until the next
// completion. start seen while busy is dropped, never queued.
interface param_serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry;

  modport master (
    output start, a, b,
    input  busy, done, sum, carry
  );

  modport slave (
    input  start, a, b,
    output busy, done, sum, carry
  );
endinterface

// File: rtl/param_serial_adder.sv
// Multi-cycle adder: adds a + b one DIGIT-bit slice per clock, LSB first.
// The result is assembled in a right-shifting partial-result register and
// published to sum/carry only on the completion edge, so the outputs never
// show partial results. WIDTH must be a positive multiple of DIGIT.
module param_serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  param_serial_adder_if.slave    bus,
  output logic [1:0]             state_o
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] acc_q;
  logic [CW-1:0]    cnt_q;
  logic             cy_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             busy_q;
  logic             done_q;

  logic [DIGIT:0]   slice_d;
  logic [WIDTH-1:0] acc_d;

  // One slice of the addition and the partial result with that slice
  // shifted in at the MSB end.
  always_comb begin
    slice_d = {1'b0, a_sh_q[DIGIT-1:0]}
            + {1'b0, b_sh_q[DIGIT-1:0]}
            + (DIGIT+1)'(cy_q);
    acc_d   = (acc_q >> DIGIT)
            | (WIDTH'(slice_d[DIGIT-1:0]) << (WIDTH - DIGIT));
  end

  // Control FSM with datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          // done is a one-cycle pulse; DONE accepts start like IDLE so
          // back-to-back operations need no idle gap.
          done_q <= 1'b0;
          if (bus.start) begin
            a_sh_q  <= bus.a;
            b_sh_q  <= bus.b;
            cy_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          acc_q  <= acc_d;
          a_sh_q <= a_sh_q >> DIGIT;
          b_sh_q <= b_sh_q >> DIGIT;
          cy_q   <= slice_d[DIGIT];
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            sum_q   <= acc_d;
            carry_q <= slice_d[DIGIT];
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.sum   = sum_q;
  assign bus.carry = carry_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_param_serial_adder.sv
// Directed checks of the serial adder with 1-bit slices (N=8) and 4-bit
// slices (N=2), plus a randomized inverse-of-subtractor sweep.
module tb_param_serial_adder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  param_serial_adder_if #(.WIDTH(8)) if1 ();
  param_serial_adder_if #(.WIDTH(8)) if4 ();
  logic [1:0] st1, st4;

  param_serial_adder #(.WIDTH(8), .DIGIT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave), .state_o(st1)
  );
  param_serial_adder #(.WIDTH(8), .DIGIT(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .bus(if4.slave), .state_o(st4)
  );

  // Currently selected DUT (0 = DIGIT 1, 1 = DIGIT 4).
  bit         sel = 1'b0;
  logic       cur_busy, cur_done, cur_carry;
  logic [7:0] cur_sum;
  assign cur_busy  = sel ? if4.busy  : if1.busy;
  assign cur_done  = sel ? if4.done  : if1.done;
  assign cur_sum   = sel ? if4.sum   : if1.sum;
  assign cur_carry = sel ? if4.carry : if1.carry;

  int n_checks = 0;
  int n_err    = 0;
  logic [8:0] exp_q[$];

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive(input logic s, input logic [7:0] av, input logic [7:0] bv);
    if (sel) begin
      if4.start = s; if4.a = av; if4.b = bv;
    end else begin
      if1.start = s; if1.a = av; if1.b = bv;
    end
  endtask

  // Called at the first negedge after the accept edge. Returns the number
  // of cycles until done is seen, how many samples had busy high, and
  // whether busy and done were ever high together.
  task automatic wait_done(output int cyc, output int busy_cnt, output bit overlap);
    cyc = 0; busy_cnt = 0; overlap = 1'b0;
    while (!cur_done && cyc < 40) begin
      if (cur_busy) busy_cnt++;
      @(negedge clk);
      cyc++;
    end
    if (cur_busy && cur_done) overlap = 1'b1;
  endtask

  // Full operation with a one-cycle start pulse.
  task automatic do_op(input bit use4, input logic [7:0] av, input logic [7:0] bv,
                       output logic [7:0] s, output logic c,
                       output int cyc, output int busy_cnt, output bit overlap);
    sel = use4;
    @(negedge clk);
    drive(1'b1, av, bv);
    @(negedge clk);
    drive(1'b0, 8'h00, 8'h00);
    wait_done(cyc, busy_cnt, overlap);
    s = cur_sum;
    c = cur_carry;
  endtask

  // Directed operation with full protocol checks.
  task automatic dir_op(input string tag, input bit use4, input logic [7:0] av,
                        input logic [7:0] bv, input logic [7:0] es, input logic ec);
    logic [7:0] s; logic c; int cyc, bc; bit ov;
    int n = use4 ? 2 : 8;
    do_op(use4, av, bv, s, c, cyc, bc, ov);
    check({tag, "_lat"},     cyc, n);
    check({tag, "_busy"},    bc, n);
    check({tag, "_overlap"}, ov, 0);
    check({tag, "_sum"},     s, es);
    check({tag, "_carry"},   c, ec);
    @(negedge clk);
    check({tag, "_pulse"},   cur_done, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] s, ra, rb, rdiff; logic c; int cyc, bc, t0; bit ov;
    logic [8:0] e;
    bit saw_done;

    sel = 0; drive(1'b0, 8'h00, 8'h00);
    sel = 1; drive(1'b0, 8'h00, 8'h00);
    sel = 0;
    #1;
    check("rst_busy1",  if1.busy,  0);
    check("rst_done1",  if1.done,  0);
    check("rst_sum1",   if1.sum,   0);
    check("rst_carry1", if1.carry, 0);
    check("rst_state1", st1,       0);
    check("rst_sum4",   if4.sum,   0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Single-bit slices.
    dir_op("d1_ff_aa", 0, 8'hFF, 8'hAA, 8'hA9, 1'b1);
    dir_op("d1_00_ff", 0, 8'h00, 8'hFF, 8'hFF, 1'b0);
    dir_op("d1_55_66", 0, 8'h55, 8'h66, 8'hBB, 1'b0);
    dir_op("d1_ff_ff", 0, 8'hFF, 8'hFF, 8'hFE, 1'b1);
    // Inverse of subtractor: diff=AB, b=66 (a=11, borrow=1).
    dir_op("inv_ab_66", 0, 8'hAB, 8'h66, 8'h11, 1'b1);

    // Four-bit slices.
    dir_op("d4_ff_01", 1, 8'hFF, 8'h01, 8'h00, 1'b1);
    dir_op("d4_ff_ff", 1, 8'hFF, 8'hFF, 8'hFE, 1'b1);
    dir_op("d4_12_34", 1, 8'h12, 8'h34, 8'h46, 1'b0);

    // Start during RUN is ignored.
    sel = 0;
    @(negedge clk); drive(1'b1, 8'h10, 8'h20);
    @(negedge clk); drive(1'b0, 8'h00, 8'h00);
    @(negedge clk);
    @(negedge clk); drive(1'b1, 8'hFF, 8'hFF);
    @(negedge clk); drive(1'b0, 8'h00, 8'h00);
    cyc = 0;
    while (!cur_done && cyc < 40) begin @(negedge clk); cyc++; end
    check("ign_lat",   cyc + 3, 8);
    check("ign_sum",   cur_sum, 8'h30);
    check("ign_carry", cur_carry, 0);
    @(negedge clk);
    check("ign_no_restart", cur_busy, 0);

    // Start held across DONE: back-to-back, 9-cycle issue interval.
    @(negedge clk); drive(1'b1, 8'h03, 8'h04);
    @(negedge clk);
    wait_done(cyc, bc, ov);
    check("b2b_first_sum", cur_sum, 8'h07);
    drive(1'b1, 8'h07, 8'h08);
    t0 = cyc;
    @(negedge clk);
    check("b2b_no_idle", cur_busy, 1);
    drive(1'b0, 8'h00, 8'h00);
    wait_done(cyc, bc, ov);
    check("b2b_interval", cyc + 1, 9);
    check("b2b_sum",      cur_sum, 8'h0F);
    check("b2b_first_lat", t0, 8);

    // Reset mid-RUN.
    @(negedge clk); @(negedge clk);
    drive(1'b1, 8'h81, 8'h81);
    @(negedge clk); drive(1'b0, 8'h00, 8'h00);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rstrun_busy",  cur_busy,  0);
    check("rstrun_done",  cur_done,  0);
    check("rstrun_sum",   cur_sum,   0);
    check("rstrun_carry", cur_carry, 0);
    check("rstrun_state", st1,       0);
    saw_done = 1'b0;
    repeat (2) begin @(negedge clk); if (cur_done) saw_done = 1'b1; end
    rst_n = 1'b1;
    repeat (10) begin @(negedge clk); if (cur_done || cur_busy) saw_done = 1'b1; end
    check("rstrun_no_done", saw_done, 0);
    dir_op("post_rst", 0, 8'h01, 8'h01, 8'h02, 1'b0);

    // Randomized inverse-of-subtractor sweep on DIGIT=1 and DIGIT=4.
    for (int i = 0; i < 1200; i++) begin
      bit u4 = (i >= 1000);
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rdiff = ra - rb;
      exp_q.push_back({(ra < rb) ? 1'b1 : 1'b0, ra});
      do_op(u4, rdiff, rb, s, c, cyc, bc, ov);
      e = exp_q.pop_front();
      check(u4 ? "sweep4" : "sweep1", {c, s}, e);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  // Global time bound.
  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
